// File: rtl/coeff_bank_ram.sv
// coeff_bank_ram: double-buffered coefficient RAM with frame-synchronous bank swap
// and an optional copy engine that refreshes the shadow bank after each swap.
module coeff_bank_ram #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int DEPTH        = 32,
    parameter int RD_LAT       = 1,
    parameter int COPY_ON_SWAP = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_d,
    output logic [DATA_W-1:0] a_q,
    output logic              a_valid,
    output logic              a_busy,
    input  logic              b_en,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [DATA_W-1:0] b_q,
    output logic              b_valid,
    input  logic              swap_req,
    input  logic              frame_sync,
    output logic              swap_pending,
    output logic              swap_done,
    output logic              active_bank
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem [2**(ADDR_W+1)];
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [DATA_W-1:0] copy_data, a_raw, b_raw;
    logic              a_raw_v, b_raw_v;
    logic              a_acc, a_in, b_in, swap_fire;

    assign a_busy    = state != IDLE;
    assign a_acc     = a_en & ~a_busy;
    assign a_in      = {1'b0, a_addr} < LIMIT;
    assign b_in      = {1'b0, b_addr} < LIMIT;
    assign swap_fire = (swap_pending | swap_req) & frame_sync & ~a_busy;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: state_nxt = (COPY_ON_SWAP != 0 && swap_fire) ? RD : IDLE;
            RD:   state_nxt = WR;
            WR:   state_nxt = idx < LAST ? RD : DONE;
            DONE: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            active_bank  <= 1'b0;
            swap_pending <= 1'b0;
            swap_done    <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= state == WR ? idx + 1'b1 : (state == IDLE ? '0 : idx);
            active_bank  <= active_bank ^ swap_fire;
            swap_pending <= ~swap_fire & (swap_pending | swap_req);
            swap_done    <= swap_fire;
        end
    end

    // Host writes and copy writes are exclusive: host access is blocked while busy.
    always_ff @(posedge clk) begin
        if (a_acc && a_we && a_in) mem[{~active_bank, a_addr}] <= a_d;
        if (state == WR) mem[{~active_bank, idx}] <= copy_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_raw     <= '0;
            a_raw_v   <= 1'b0;
            b_raw     <= '0;
            b_raw_v   <= 1'b0;
            copy_data <= '0;
        end else begin
            a_raw_v <= a_acc;
            b_raw_v <= b_en;
            if (a_acc) a_raw <= a_in ? (a_we ? a_d : mem[{~active_bank, a_addr}]) : '0;
            if (b_en) b_raw <= b_in ? mem[{active_bank, b_addr}] : '0;
            if (state == RD) copy_data <= mem[{active_bank, idx}];
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q     <= '0;
                    a_valid <= 1'b0;
                    b_q     <= '0;
                    b_valid <= 1'b0;
                end else begin
                    a_q     <= a_raw;
                    a_valid <= a_raw_v;
                    b_q     <= b_raw;
                    b_valid <= b_raw_v;
                end
            end
        end else begin : g_lat1
            assign a_q     = a_raw;
            assign a_valid = a_raw_v;
            assign b_q     = b_raw;
            assign b_valid = b_raw_v;
        end
    endgenerate
endmodule

// File: tb/tb_coeff_bank_ram.sv
// tb_coeff_bank_ram: directed checks of bank swap, copy engine, reset abort and RD_LAT=2 variant.
module tb_coeff_bank_ram;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        a_en = 0, a_we = 0, b_en = 0, swap_req = 0, frame_sync = 0;
    logic [4:0]  a_addr = 0, b_addr = 0;
    logic [31:0] a_d = 0;
    logic [31:0] a_q, b_q;
    logic        a_valid, a_busy, b_valid, swap_pending, swap_done, active_bank;
    logic        a_en2 = 0, a_we2 = 0, b_en2 = 0, swap_req2 = 0, frame_sync2 = 0;
    logic [4:0]  a_addr2 = 0, b_addr2 = 0;
    logic [31:0] a_d2 = 0;
    logic [31:0] a_q2, b_q2;
    logic        a_valid2, a_busy2, b_valid2, swap_pending2, swap_done2, active_bank2;
    int          total = 0, bad = 0, busy = 0;

    always #5 clk = ~clk;

    coeff_bank_ram dut (
        .clk(clk), .rst(rst), .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_d(a_d),
        .a_q(a_q), .a_valid(a_valid), .a_busy(a_busy), .b_en(b_en), .b_addr(b_addr),
        .b_q(b_q), .b_valid(b_valid), .swap_req(swap_req), .frame_sync(frame_sync),
        .swap_pending(swap_pending), .swap_done(swap_done), .active_bank(active_bank)
    );

    coeff_bank_ram #(.DEPTH(20), .RD_LAT(2), .COPY_ON_SWAP(0)) dut2 (
        .clk(clk), .rst(rst), .a_en(a_en2), .a_we(a_we2), .a_addr(a_addr2), .a_d(a_d2),
        .a_q(a_q2), .a_valid(a_valid2), .a_busy(a_busy2), .b_en(b_en2), .b_addr(b_addr2),
        .b_q(b_q2), .b_valid(b_valid2), .swap_req(swap_req2), .frame_sync(frame_sync2),
        .swap_pending(swap_pending2), .swap_done(swap_done2), .active_bank(active_bank2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_op(input logic we, input logic [4:0] addr, input logic [31:0] d);
        a_en = 1; a_we = we; a_addr = addr; a_d = d;
        step();
        a_en = 0; a_we = 0;
    endtask

    function automatic logic [31:0] f(input int k);
        return k == 3 ? 32'h1234_5678 : 32'hA000_0000 + k;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        step(); step();
        rst = 0;
        chk("rst_a_q", a_q, 0);
        chk("rst_b_q", b_q, 0);
        chk("rst_valids", {a_valid, b_valid}, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_swap", {swap_pending, swap_done, active_bank}, 0);

        for (int k = 0; k < 32; k++) begin
            a_op(1, 5'(k), f(k));
            chk("wr_first", a_q, f(k));
            chk("wr_valid", a_valid, 1);
        end
        step();
        chk("a_valid_drop", a_valid, 0);
        a_op(0, 3, 0);
        chk("rd_shadow", a_q, 32'h1234_5678);
        chk("rd_valid", a_valid, 1);
        b_en = 1; b_addr = 3;
        step();
        b_en = 0;
        chk("b_valid", b_valid, 1);

        swap_req = 1;
        step();
        swap_req = 0;
        for (int c = 11; c <= 20; c++) begin
            chk("pend_wait", {swap_pending, swap_done, active_bank}, 3'b100);
            frame_sync = c == 20;
            step();
            frame_sync = 0;
        end
        chk("swap_applied", {swap_pending, swap_done, active_bank}, 3'b011);

        for (int c = 0; c < 100; c++) begin
            if (a_busy) busy++;
            if (c == 1) begin
                chk("b_new_bank", b_q, 32'h1234_5678);
                chk("done_one_cyc", swap_done, 0);
            end
            if (c == 2) chk("busy_no_valid", a_valid, 0);
            if (c == 4) chk("pend_in_busy", swap_pending, 1);
            if (c == 6) chk("no_swap_busy", active_bank, 1);
            b_en = c == 0; b_addr = 3;
            a_en = c == 1; a_we = c == 1; a_addr = 5; a_d = 32'h0000_0BAD;
            swap_req = c == 3; frame_sync = c == 5;
            step();
        end
        b_en = 0; a_en = 0; a_we = 0; swap_req = 0; frame_sync = 0;
        chk("busy_len", busy, 65);
        chk("pend_kept", {swap_pending, active_bank}, 2'b11);

        for (int k = 0; k < 32; k++) begin
            a_op(0, 5'(k), 0);
            chk("copy_readback", a_q, f(k));
        end

        frame_sync = 1;
        step();
        frame_sync = 0;
        chk("swap_after_busy", {swap_pending, swap_done, active_bank}, 3'b010);
        for (int c = 0; c < 100 && a_busy; c++) step();
        chk("copy2_end", a_busy, 0);

        a_op(1, 3, 32'hDEAD_BEEF);
        chk("wr_deadbeef", a_q, 32'hDEAD_BEEF);
        swap_req = 1; frame_sync = 1; b_en = 1; b_addr = 3;
        step();
        swap_req = 0; frame_sync = 0;
        chk("imm_swap", {swap_pending, swap_done, active_bank}, 3'b011);
        chk("b_old_bank", b_q, 32'h1234_5678);
        step();
        b_en = 0;
        chk("b_next_bank", b_q, 32'hDEAD_BEEF);
        chk("imm_done_end", {swap_pending, swap_done}, 0);

        repeat (19) step();
        rst = 1;
        step();
        rst = 0;
        chk("abort_busy", a_busy, 0);
        chk("abort_bank", active_bank, 0);
        b_en = 1; b_addr = 3;
        step();
        b_en = 0;
        chk("abort_b_valid", b_valid, 1);
        chk("abort_kept", b_q, 32'hDEAD_BEEF);
        step();
        chk("abort_b_drop", b_valid, 0);

        a_en2 = 1; a_we2 = 1; a_addr2 = 4; a_d2 = 32'h55;
        step();
        a_en2 = 0; a_we2 = 0;
        chk("l2_wr_early", a_valid2, 0);
        step();
        chk("l2_wr_valid", a_valid2, 1);
        chk("l2_wr_q", a_q2, 32'h55);
        a_en2 = 1; a_addr2 = 25;
        step();
        a_en2 = 0;
        step();
        chk("l2_oor_valid", a_valid2, 1);
        chk("l2_oor_q", a_q2, 0);
        swap_req2 = 1; frame_sync2 = 1;
        step();
        swap_req2 = 0; frame_sync2 = 0;
        chk("l2_swap", active_bank2, 1);
        chk("l2_no_copy", a_busy2, 0);
        b_en2 = 1; b_addr2 = 4;
        step();
        b_en2 = 0;
        chk("l2_b_early", b_valid2, 0);
        step();
        chk("l2_b_valid", b_valid2, 1);
        chk("l2_b_q", b_q2, 32'h55);
        step();
        chk("l2_b_drop", b_valid2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
